// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet parser.
package uart_pkt_pkg;

  // Parser FSM states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Error codes reported on err_code_o.
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Default start-of-frame marker.
  localparam logic [7:0] SOF_BYTE_DFLT = 8'hA5;

  // Running checksum step: 8-bit wrapping add.
  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: MAX_LEN x 8 register file, synchronous write, combinational read.
module uart_pkt_buf #(
  parameter int MAX_LEN = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  // Contents are don't-care after reset, so the storage has no reset.
  logic [7:0] mem_q [MAX_LEN];

  // Write one payload byte per accepted strobe.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_packet_parser.sv
// Frames SOF|LEN|PAYLOAD|CSUM from the UART byte stream, verifies the
// checksum and then releases the stored payload on a valid/ready stream.
module uart_rx_packet_parser
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DFLT,
  parameter int         TIMEOUT_CYCLES = 208_330
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_valid_i,
  output logic [7:0] pkt_data_o,
  output logic       pkt_valid_o,
  input  logic       pkt_ready_i,
  output logic       pkt_last_o,
  output logic [7:0] pkt_len_o,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       rx_overrun_o
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int         TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  // The counter value in the cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       sum_q, sum_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             frame_ok_q, frame_ok_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             overrun_q, overrun_d;

  logic             buf_we_s;
  logic [7:0]       rd_data_s;
  logic             last_s;
  logic             drain_s;

  uart_pkt_buf #(
    .MAX_LEN (MAX_LEN),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk     (clk),
    .we_i    (buf_we_s),
    .waddr_i (wr_idx_q),
    .wdata_i (rx_byte_i),
    .raddr_i (rd_idx_q),
    .rdata_o (rd_data_s)
  );

  assign drain_s = (state_q == DRAIN);
  assign last_s  = (8'(rd_idx_q) == (len_q - 8'd1));

  // Outputs are gated by DRAIN so reset forces them to zero regardless of buffer contents.
  assign pkt_valid_o  = drain_s;
  assign pkt_data_o   = drain_s ? rd_data_s : 8'h00;
  assign pkt_last_o   = drain_s & last_s;
  assign pkt_len_o    = drain_s ? len_q : 8'h00;
  assign frame_ok_o   = frame_ok_q;
  assign frame_err_o  = frame_err_q;
  assign err_code_o   = err_code_q;
  assign rx_overrun_o = overrun_q;

  // Next-state, datapath and pulse generation for the frame parser.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    to_cnt_d    = to_cnt_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    overrun_d   = 1'b0;
    buf_we_s    = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (rx_valid_i && (rx_byte_i == SOF_BYTE)) begin
          state_d = LEN;
        end else begin
          state_d = IDLE;
        end
      end

      LEN, PAYLOAD, CSUM: begin
        if (rx_valid_i) begin
          // A byte always wins over a coincident timeout.
          to_cnt_d = '0;
          if (state_q == LEN) begin
            len_d = rx_byte_i;
            sum_d = rx_byte_i;
            if ((rx_byte_i == 8'd0) || (rx_byte_i > MAX_LEN_B)) begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_LEN;
              state_d     = IDLE;
            end else begin
              wr_idx_d = '0;
              state_d  = PAYLOAD;
            end
          end else if (state_q == PAYLOAD) begin
            buf_we_s = 1'b1;
            sum_d    = csum_add(sum_q, rx_byte_i);
            wr_idx_d = wr_idx_q + IDX_W'(1);
            if (8'(wr_idx_q) == (len_q - 8'd1)) begin
              state_d = CSUM;
            end else begin
              state_d = PAYLOAD;
            end
          end else begin
            if (csum_add(sum_q, rx_byte_i) == 8'h00) begin
              frame_ok_d = 1'b1;
              rd_idx_d   = '0;
              state_d    = DRAIN;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = ERR_CSUM;
              state_d     = IDLE;
            end
          end
        end else if (to_cnt_q == TO_LAST) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          to_cnt_d    = '0;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      DRAIN: begin
        to_cnt_d  = '0;
        overrun_d = rx_valid_i;
        if (pkt_ready_i) begin
          rd_idx_d = rd_idx_q + IDX_W'(1);
          if (last_s) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= 8'h00;
      sum_q       <= 8'h00;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      to_cnt_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      to_cnt_q    <= to_cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      overrun_q   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Directed bench for uart_rx_packet_parser with hand-computed expectations.
module tb_uart_rx_packet_parser;

  localparam int TO = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       rx_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_packet_parser #(
    .MAX_LEN        (16),
    .SOF_BYTE       (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte_i    (rx_byte),
    .rx_valid_i   (rx_valid),
    .pkt_data_o   (pkt_data),
    .pkt_valid_o  (pkt_valid),
    .pkt_ready_i  (pkt_ready),
    .pkt_last_o   (pkt_last),
    .pkt_len_o    (pkt_len),
    .frame_ok_o   (frame_ok),
    .frame_err_o  (frame_err),
    .err_code_o   (err_code),
    .rx_overrun_o (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte for exactly one clock edge; returns 1 unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A5 03 11 22 33 97 with ready high: checksum 03+11+22+33+97 = 0x100.
  task automatic good3(input string tag);
    pkt_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h97);
    chk({tag, "_ok"},    {31'd0, frame_ok},  32'd1);
    chk({tag, "_err0"},  {31'd0, frame_err}, 32'd0);
    chk({tag, "_v0"},    {31'd0, pkt_valid}, 32'd1);
    chk({tag, "_d0"},    {24'd0, pkt_data},  32'h11);
    chk({tag, "_l0"},    {31'd0, pkt_last},  32'd0);
    chk({tag, "_len"},   {24'd0, pkt_len},   32'd3);
    step();
    chk({tag, "_ok1"},   {31'd0, frame_ok},  32'd0);
    chk({tag, "_d1"},    {24'd0, pkt_data},  32'h22);
    chk({tag, "_l1"},    {31'd0, pkt_last},  32'd0);
    step();
    chk({tag, "_d2"},    {24'd0, pkt_data},  32'h33);
    chk({tag, "_l2"},    {31'd0, pkt_last},  32'd1);
    chk({tag, "_len2"},  {24'd0, pkt_len},   32'd3);
    step();
    chk({tag, "_vend"},  {31'd0, pkt_valid}, 32'd0);
  endtask

  initial begin
    logic seen;
    rst_n     = 1'b0;
    rx_byte   = 8'h00;
    rx_valid  = 1'b0;
    pkt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, pkt_valid},  32'd0);
    chk("rst_data",  {24'd0, pkt_data},   32'd0);
    chk("rst_ok",    {31'd0, frame_ok},   32'd0);
    chk("rst_err",   {31'd0, frame_err},  32'd0);
    chk("rst_code",  {30'd0, err_code},   32'd0);
    chk("rst_ovr",   {31'd0, rx_overrun}, 32'd0);
    rst_n = 1'b1;
    step();

    good3("good");

    // Bad checksum.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h98);
    chk("csum_err",   {31'd0, frame_err}, 32'd1);
    chk("csum_code",  {30'd0, err_code},  32'd2);
    chk("csum_ok",    {31'd0, frame_ok},  32'd0);
    chk("csum_v",     {31'd0, pkt_valid}, 32'd0);
    step();
    chk("csum_err1",  {31'd0, frame_err}, 32'd0);
    chk("csum_hold",  {30'd0, err_code},  32'd2);
    chk("csum_v1",    {31'd0, pkt_valid}, 32'd0);
    good3("after_csum");

    // LEN above MAX_LEN.
    send_byte(8'hA5); send_byte(8'h11);
    chk("len17_err",  {31'd0, frame_err}, 32'd1);
    chk("len17_code", {30'd0, err_code},  32'd1);
    step();
    // Garbage then zero length.
    send_byte(8'h00); send_byte(8'hFF);
    chk("garb_err",   {31'd0, frame_err}, 32'd0);
    send_byte(8'hA5); send_byte(8'h00);
    chk("len0_err",   {31'd0, frame_err}, 32'd1);
    chk("len0_code",  {30'd0, err_code},  32'd1);
    step();

    // Maximum length: LEN 0x10, payload 00..0F, sum 0x88, checksum 0x78.
    pkt_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h78);
    chk("max_ok",     {31'd0, frame_ok}, 32'd1);
    chk("max_len",    {24'd0, pkt_len},  32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("max_d", {24'd0, pkt_data}, 32'(i));
      chk("max_l", {31'd0, pkt_last}, (i == 15) ? 32'd1 : 32'd0);
      step();
    end
    chk("max_vend",   {31'd0, pkt_valid}, 32'd0);

    // Timeout: frame_err exactly TO edges after the last accepted byte.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    seen = 1'b0;
    for (int k = 1; k < TO; k++) begin
      step();
      seen = seen | frame_err;
    end
    chk("to_early",   {31'd0, seen},      32'd0);
    step();
    chk("to_err",     {31'd0, frame_err}, 32'd1);
    chk("to_code",    {30'd0, err_code},  32'd3);
    step();
    chk("to_err1",    {31'd0, frame_err}, 32'd0);
    good3("after_to");

    // Backpressure with an SOF arriving during DRAIN.
    pkt_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h97);
    chk("bp_ok",      {31'd0, frame_ok},   32'd1);
    chk("bp_d0",      {24'd0, pkt_data},   32'h11);
    repeat (10) step();
    send_byte(8'hA5);
    chk("bp_ovr",     {31'd0, rx_overrun}, 32'd1);
    chk("bp_ovr_ok",  {31'd0, frame_ok},   32'd0);
    chk("bp_ovr_err", {31'd0, frame_err},  32'd0);
    chk("bp_d_ovr",   {24'd0, pkt_data},   32'h11);
    step();
    chk("bp_ovr1",    {31'd0, rx_overrun}, 32'd0);
    repeat (38) step();
    chk("bp_v_hold",  {31'd0, pkt_valid},  32'd1);
    chk("bp_d_hold",  {24'd0, pkt_data},   32'h11);
    chk("bp_l_hold",  {31'd0, pkt_last},   32'd0);
    pkt_ready = 1'b1;
    step();
    chk("bp_d1",      {24'd0, pkt_data},   32'h22);
    step();
    chk("bp_d2",      {24'd0, pkt_data},   32'h33);
    chk("bp_l2",      {31'd0, pkt_last},   32'd1);
    step();
    chk("bp_vend",    {31'd0, pkt_valid},  32'd0);

    // Asynchronous reset in DRAIN: outputs drop before any clock edge.
    pkt_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h97);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rstd_v",     {31'd0, pkt_valid},  32'd0);
    chk("rstd_d",     {24'd0, pkt_data},   32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-PAYLOAD, then a clean frame.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("rstp_err",   {31'd0, frame_err},  32'd0);
    chk("rstp_code",  {30'd0, err_code},   32'd0);
    step();
    rst_n = 1'b1;
    step();
    good3("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
